// File: rtl/mem_arbiter.sv
// mem_arbiter: registered round-robin arbiter sharing one single-port memory between two requesters.
// Define MEM_ARB_LOCK_EN to add lock0/lock1 inputs that give one port exclusive ownership.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
`ifdef MEM_ARB_LOCK_EN
  input  logic              lock0,
  input  logic              lock1,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE0 = 2'd1,
    ISSUE1 = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic              r_last;
  logic              w_lastEff;
  logic              w_nextLast;
  logic              w_elig0;
  logic              w_elig1;
  logic              w_win0;
  logic              w_win1;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              r_memWe;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic              w_lockHold;
  logic              w_lockRelease;
  logic              w_lockOwner;

`ifdef MEM_ARB_LOCK_EN
  logic r_lockActive;
  logic r_lockOwner;
  logic w_ownerLock;

  assign w_ownerLock   = r_lockOwner ? lock1 : lock0;
  assign w_lockOwner   = r_lockOwner;
  assign w_lockHold    = r_lockActive && w_ownerLock;
  assign w_lockRelease = r_lockActive && !w_ownerLock;

  // Ownership is taken at a winning edge with lock set and dropped at the edge the owner's lock is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lockActive <= 1'b0;
      r_lockOwner  <= 1'b0;
    end else if (w_win0 && lock0) begin
      r_lockActive <= 1'b1;
      r_lockOwner  <= 1'b0;
    end else if (w_win1 && lock1) begin
      r_lockActive <= 1'b1;
      r_lockOwner  <= 1'b1;
    end else if (w_lockRelease) begin
      r_lockActive <= 1'b0;
    end
  end
`else
  assign w_lockHold    = 1'b0;
  assign w_lockRelease = 1'b0;
  assign w_lockOwner   = 1'b0;
`endif

  // A port is not eligible in its own grant cycle, so a held request alternates with the other port.
  assign w_elig0 = req0 && !w_gnt0;
  assign w_elig1 = req1 && !w_gnt1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_nextState;
      r_last  <= w_nextLast;
    end
  end

  // On lock release the pointer restarts as if the former owner had just won a contention.
  always_comb begin
    w_win0      = 1'b0;
    w_win1      = 1'b0;
    w_lastEff   = w_lockRelease ? w_lockOwner : r_last;
    w_nextLast  = w_lastEff;
    w_nextState = IDLE;
    if (w_lockHold) begin
      if (w_lockOwner) begin
        w_win1 = w_elig1;
      end else begin
        w_win0 = w_elig0;
      end
    end else if (w_elig0 && w_elig1) begin
      w_win0     = w_lastEff;
      w_win1     = !w_lastEff;
      w_nextLast = !w_lastEff;
    end else begin
      w_win0 = w_elig0;
      w_win1 = w_elig1;
    end
    if (w_win0) begin
      w_nextState = ISSUE0;
    end else if (w_win1) begin
      w_nextState = ISSUE1;
    end
  end

  always_comb begin
    w_gnt0 = (r_state == ISSUE0);
    w_gnt1 = (r_state == ISSUE1);
    mem_en = (r_state != IDLE);
  end

  // Command fields are captured at the arbitration edge; address and data hold while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
    end else if (w_win0) begin
      r_memWe    <= we0;
      r_memAddr  <= addr0;
      r_memWdata <= wdata0;
    end else if (w_win1) begin
      r_memWe    <= we1;
      r_memAddr  <= addr1;
      r_memWdata <= wdata1;
    end else begin
      r_memWe    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= (r_state == ISSUE0) && !r_memWe;
      r_rvalid1 <= (r_state == ISSUE1) && !r_memWe;
    end
  end

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign mem_we    = r_memWe;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign rvalid0   = r_rvalid0;
  assign rvalid1   = r_rvalid1;
  assign rdata0    = r_rvalid0 ? mem_rdata : '0;
  assign rdata1    = r_rvalid1 ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized scoreboard bench for mem_arbiter with a behavioural memory.
module tb_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [15:0] data;
    int          cyc;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, gnt0, rvalid0;
  logic [7:0]  addr0;
  logic [15:0] wdata0, rdata0;
  logic        req1, we1, gnt1, rvalid1;
  logic [7:0]  addr1;
  logic [15:0] wdata1, rdata1;
  logic [7:0]  mem_addr;
  logic        mem_en, mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] memRdata;
`ifdef MEM_ARB_LOCK_EN
  logic        lock0 = 1'b0;
  logic        lock1 = 1'b0;
`endif

  cmd_t        cmdQ0[$];
  cmd_t        cmdQ1[$];
  rd_t         rdQ0[$];
  rd_t         rdQ1[$];
  logic [15:0] envMem[256];
  logic [15:0] refMem[256];
  int          cyc = 0;
  int          testsRun = 0;
  int          testsFailed = 0;
  logic        predG0 = 1'b0;
  logic        predG1 = 1'b0;
  logic        modelLast = 1'b1;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
`ifdef MEM_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(memRdata)
  );

  // Behavioural single-port memory with one cycle of read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      if (mem_we) envMem[mem_addr] <= mem_wdata;
      else memRdata <= envMem[mem_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic setPort(input int p, input logic req, input logic we, input logic [7:0] addr,
                         input logic [15:0] wdata);
    if (p == 0) begin
      req0 = req; we0 = we; addr0 = addr; wdata0 = wdata;
    end else begin
      req1 = req; we1 = we; addr1 = addr; wdata1 = wdata;
    end
  endtask

  // Raise a request, log it for the scoreboard and wait (bounded) for its grant cycle.
  task automatic applyStimulus(input int p, input logic we, input logic [7:0] addr,
                               input logic [15:0] wdata, output int lat);
    cmd_t c;
    logic g;
    c.we = we; c.addr = addr; c.wdata = wdata;
    setPort(p, 1'b1, we, addr, wdata);
    if (p == 0) cmdQ0.push_back(c);
    else cmdQ1.push_back(c);
    lat = 0;
    g = 1'b0;
    while (!g && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
      g = (p == 0) ? gnt0 : gnt1;
    end
    if (!g) checkOutput(p == 0 ? "p0 grant timeout" : "p1 grant timeout", 32'd0, 32'd1);
  endtask

  task automatic readCheck(input int p, input logic [7:0] addr, input logic [15:0] exp, input string name);
    int lat;
    applyStimulus(p, 1'b0, addr, 16'h0, lat);
    setPort(p, 1'b0, 1'b0, 8'h0, 16'h0);
    @(posedge clk);
    #1;
    checkOutput({name, " rvalid"}, (p == 0) ? rvalid0 : rvalid1, 1);
    checkOutput({name, " rdata"}, (p == 0) ? rdata0 : rdata1, exp);
  endtask

  task automatic doReset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic monitorRead(input int p);
    logic        v;
    logic [15:0] d;
    rd_t         e;
    int          n;
    v = (p == 0) ? rvalid0 : rvalid1;
    d = (p == 0) ? rdata0 : rdata1;
    n = (p == 0) ? rdQ0.size() : rdQ1.size();
    if (v) begin
      if (n == 0) begin
        checkOutput(p == 0 ? "p0 unexpected rvalid" : "p1 unexpected rvalid", 32'd1, 32'd0);
      end else begin
        e = (p == 0) ? rdQ0.pop_front() : rdQ1.pop_front();
        checkOutput(p == 0 ? "p0 rdata" : "p1 rdata", d, e.data);
        checkOutput(p == 0 ? "p0 rvalid cycle" : "p1 rvalid cycle", cyc, e.cyc);
      end
    end else begin
      checkOutput(p == 0 ? "p0 rdata idle" : "p1 rdata idle", d, 0);
      if (n != 0) begin
        e = (p == 0) ? rdQ0[0] : rdQ1[0];
        if (e.cyc <= cyc) begin
          checkOutput(p == 0 ? "p0 missing rvalid" : "p1 missing rvalid", 32'd0, 32'd1);
          if (p == 0) void'(rdQ0.pop_front());
          else void'(rdQ1.pop_front());
        end
      end
    end
  endtask

  // A granted command must be the oldest outstanding request of that port; reads look up the model memory.
  task automatic monitorGrant(input int p);
    cmd_t c;
    rd_t  r;
    int   n;
    n = (p == 0) ? cmdQ0.size() : cmdQ1.size();
    if (n == 0) begin
      checkOutput(p == 0 ? "p0 grant without request" : "p1 grant without request", 32'd1, 32'd0);
    end else begin
      c = (p == 0) ? cmdQ0.pop_front() : cmdQ1.pop_front();
      checkOutput(p == 0 ? "p0 mem_addr" : "p1 mem_addr", mem_addr, c.addr);
      checkOutput(p == 0 ? "p0 mem_we" : "p1 mem_we", mem_we, c.we);
      if (c.we) begin
        checkOutput(p == 0 ? "p0 mem_wdata" : "p1 mem_wdata", mem_wdata, c.wdata);
        refMem[c.addr] = c.wdata;
      end else begin
        r.data = refMem[c.addr];
        r.cyc  = cyc + 1;
        if (p == 0) rdQ0.push_back(r);
        else rdQ1.push_back(r);
      end
    end
  endtask

  always @(negedge clk) begin
    logic e0, e1;
    if (!rst) begin
      checkOutput("reset gnt", {gnt0, gnt1}, 0);
      checkOutput("reset rvalid", {rvalid0, rvalid1}, 0);
      checkOutput("reset mem_en/we", {mem_en, mem_we}, 0);
      checkOutput("reset mem_addr", mem_addr, 0);
      checkOutput("reset mem_wdata", mem_wdata, 0);
      cmdQ0.delete(); cmdQ1.delete(); rdQ0.delete(); rdQ1.delete();
      predG0 = 1'b0; predG1 = 1'b0; modelLast = 1'b1;
    end else begin
      monitorRead(0);
      monitorRead(1);
      checkOutput("rvalid overlap", rvalid0 & rvalid1, 0);
      checkOutput("gnt0", gnt0, predG0);
      checkOutput("gnt1", gnt1, predG1);
      checkOutput("mem_en", mem_en, predG0 | predG1);
      if (gnt0) monitorGrant(0);
      if (gnt1) monitorGrant(1);
      // Round-robin reference: requests are ignored in their own grant cycle, ties go to the port that is not last.
      e0 = req0 && !predG0;
      e1 = req1 && !predG1;
      if (e0 && e1) begin
        predG0    = modelLast;
        predG1    = !modelLast;
        modelLast = !modelLast;
      end else begin
        predG0 = e0;
        predG1 = e1;
      end
    end
  end

  task automatic randomPort(input int p, input int n);
    int          lat;
    int          gap;
    int          sel;
    logic [7:0]  a;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 3);
      if (gap > 1) begin
        setPort(p, 1'b0, 1'b0, 8'h0, 16'h0);
        repeat (gap - 1) begin
          @(posedge clk);
          #1;
        end
      end
      sel = $urandom_range(0, 7);
      a = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom_range(0, 255));
      applyStimulus(p, 1'($urandom_range(0, 1)), a, 16'($urandom), lat);
    end
    setPort(p, 1'b0, 1'b0, 8'h0, 16'h0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int latA[4];
    int latB[4];
    rst = 1'b0;
    setPort(0, 1'b0, 1'b0, 8'h0, 16'h0);
    setPort(1, 1'b0, 1'b0, 8'h0, 16'h0);
    for (int i = 0; i < 256; i++) begin
      envMem[i] = 16'($urandom);
      refMem[i] = envMem[i];
    end
    envMem[5] = 16'hBEEF;
    refMem[5] = 16'hBEEF;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Uncontended read: grant one cycle after the request, data one cycle later.
    applyStimulus(0, 1'b0, 8'h05, 16'h0, lat);
    checkOutput("t1 gnt latency", lat, 1);
    setPort(0, 1'b0, 1'b0, 8'h0, 16'h0);
    @(posedge clk);
    #1;
    checkOutput("t1 rvalid0", rvalid0, 1);
    checkOutput("t1 rdata0", rdata0, 16'hBEEF);
    checkOutput("t1 rvalid1", rvalid1, 0);

    // Write then read on port 1; the read request is ignored during the write's grant cycle.
    applyStimulus(1, 1'b1, 8'h10, 16'h1234, lat);
    checkOutput("t2 write latency", lat, 1);
    applyStimulus(1, 1'b0, 8'h10, 16'h0, lat);
    checkOutput("t2 read latency", lat, 2);
    setPort(1, 1'b0, 1'b0, 8'h0, 16'h0);
    @(posedge clk);
    #1;
    checkOutput("t2 rvalid1", rvalid1, 1);
    checkOutput("t2 rdata1", rdata1, 16'h1234);

    // Address extremes.
    applyStimulus(0, 1'b1, 8'hFF, 16'hA5A5, lat);
    applyStimulus(0, 1'b1, 8'h00, 16'h5A5A, lat);
    setPort(0, 1'b0, 1'b0, 8'h0, 16'h0);
    readCheck(0, 8'hFF, 16'hA5A5, "t5 addr FF");
    readCheck(1, 8'h00, 16'h5A5A, "t5 addr 00");

    // Continuous contention from reset: strict 0,1,0,1 alternation.
    doReset();
    fork
      begin
        for (int i = 0; i < 4; i++) applyStimulus(0, 1'b0, 8'(8'h20 + i), 16'h0, latA[i]);
        setPort(0, 1'b0, 1'b0, 8'h0, 16'h0);
      end
      begin
        for (int i = 0; i < 4; i++) applyStimulus(1, 1'b0, 8'(8'h40 + i), 16'h0, latB[i]);
        setPort(1, 1'b0, 1'b0, 8'h0, 16'h0);
      end
    join
    checkOutput("t3 p0 first latency", latA[0], 1);
    for (int i = 1; i < 4; i++) checkOutput("t3 p0 latency", latA[i], 2);
    for (int i = 0; i < 4; i++) checkOutput("t3 p1 latency", latB[i], 2);
    repeat (2) @(posedge clk);
    #1;

    // Reset between a read grant and its data: outputs clear at once and the read is dropped.
    applyStimulus(0, 1'b0, 8'h33, 16'h0, lat);
    setPort(0, 1'b0, 1'b0, 8'h0, 16'h0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t4 async gnt0", gnt0, 0);
    checkOutput("t4 async mem_en", mem_en, 0);
    checkOutput("t4 async mem_addr", mem_addr, 0);
    @(posedge clk);
    #1;
    checkOutput("t4 rvalid0 dropped", rvalid0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t4 rvalid0 after reset", rvalid0, 0);

    fork
      randomPort(0, 40);
      randomPort(1, 40);
    join
    repeat (5) @(posedge clk);
    #1;
    checkOutput("cmdQ drained", cmdQ0.size() + cmdQ1.size(), 0);
    checkOutput("rdQ drained", rdQ0.size() + rdQ1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
